// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the iterative divider
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    // Quotient returned on divide-by-zero, for both DIV and DIVU
    localparam logic [DIV_WIDTH-1:0] DIVZ_QUO = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_FIX,
        S_DONE
    } div_state_e;

endpackage

// File: rtl/div_abs_neg.sv
// rtl/div_abs_neg.sv - conditional two's-complement negate
module div_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             negate_i,
    output logic [WIDTH-1:0] value_o
);

    assign value_o = negate_i ? (~value_i + 1'b1) : value_i;

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring divider for DIV/DIVU with pipeline stall
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    output logic               stall,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    div_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0]   rem_d, quo_d;
    logic               qneg_q, rneg_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [WIDTH:0]     shifted, trial;
    logic               borrow;

    assign a_neg = signed_div & a[WIDTH-1];
    assign b_neg = signed_div & b[WIDTH-1];

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.value_i(a),     .negate_i(a_neg),  .value_o(a_mag));
    div_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.value_i(b),     .negate_i(b_neg),  .value_o(b_mag));
    div_abs_neg #(.WIDTH(WIDTH)) u_fix_q (.value_i(quo_q), .negate_i(qneg_q), .value_o(quo_fix));
    div_abs_neg #(.WIDTH(WIDTH)) u_fix_r (.value_i(rem_q), .negate_i(rneg_q), .value_o(rem_fix));

    // Remainder stays below the divisor, so the top bit of the trial result is the borrow
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign borrow  = trial[WIDTH];
    assign rem_d   = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_d   = {quo_q[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else if (annul) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    if (start) begin
                        if (b == '0) begin
                            result_q <= {a, DIVZ_QUO};
                            ready_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            quo_q   <= a_mag;
                            dvs_q   <= b_mag;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= {rem_fix, quo_fix};
                    ready_q  <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    ready_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Released in DONE so the requesting stage advances in the ready cycle
    assign stall  = start & (state_q != S_DONE) & ~annul;
    assign ready  = ready_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - table-driven scoreboard bench for div_unit
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, signed_div, annul;
    logic [31:0] a, b;
    logic        stall, ready;
    logic [63:0] result;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
        .a(a), .b(b), .annul(annul),
        .stall(stall), .ready(ready), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic        sgn;
        logic [63:0] exp;
        int          stalls;
    } vec_t;

    vec_t        vecs[12];
    logic [63:0] sb[$];
    logic [63:0] last_exp;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic ts, input logic [63:0] exp, input int exp_stalls);
        int          stalls;
        logic        got;
        logic [63:0] want;
        @(posedge clk);
        #1;
        a = ta; b = tb_; signed_div = ts; start = 1'b1;
        sb.push_back(exp);
        stalls = 0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                check({name, " stall_in_ready"}, {63'd0, stall}, 64'd0);
                want = sb.pop_front();
                check({name, " result"}, result, want);
                last_exp = want;
            end else if (stall) begin
                stalls++;
            end
        end
        start = 1'b0;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: got no ready expected ready", name);
            sb.delete();
        end
        check({name, " stall_cycles"}, 64'(stalls), 64'(exp_stalls));
        @(negedge clk);
        check({name, " ready_pulse"}, {63'd0, ready}, 64'd0);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check({name, " no_ready"}, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        vecs[0]  = '{32'd100,       32'd7,          1'b0, {32'd2,         32'd14},        34};
        vecs[1]  = '{32'hFFFFFFF9,  32'd2,          1'b1, {32'hFFFFFFFF,  32'hFFFFFFFD},  34};
        vecs[2]  = '{32'd7,         32'hFFFFFFFE,   1'b1, {32'h00000001,  32'hFFFFFFFD},  34};
        vecs[3]  = '{32'h12345678,  32'd0,          1'b1, {32'h12345678,  32'hFFFFFFFF},  1};
        vecs[4]  = '{32'h12345678,  32'd0,          1'b0, {32'h12345678,  32'hFFFFFFFF},  1};
        vecs[5]  = '{32'h80000000,  32'hFFFFFFFF,   1'b1, {32'h00000000,  32'h80000000},  34};
        vecs[6]  = '{32'hFFFFFFFF,  32'd1,          1'b0, {32'h00000000,  32'hFFFFFFFF},  34};
        vecs[7]  = '{32'hFFFFFFFF,  32'h10,         1'b0, {32'h0000000F,  32'h0FFFFFFF},  34};
        vecs[8]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,   1'b1, {32'hFFFFFFFE,  32'h0000000E},  34};
        vecs[9]  = '{32'd1000,      32'd1000,       1'b0, {32'd0,         32'd1},         34};
        vecs[10] = '{32'd5,         32'd10,         1'b0, {32'd5,         32'd0},         34};
        vecs[11] = '{32'h80000000,  32'hFFFFFFFF,   1'b0, {32'h80000000,  32'h00000000},  34};

        rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
        last_exp = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset result", result, 64'd0);
        check("reset ready", {63'd0, ready}, 64'd0);
        check("reset stall", {63'd0, stall}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].sgn,
                   vecs[i].exp, vecs[i].stalls);
        end

        // annul during the tenth divide step, with start still asserted
        @(posedge clk);
        #1 a = 32'd1000000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (11) @(posedge clk);
        #1 annul = 1'b1;
        #2 check("annul stall", {63'd0, stall}, 64'd0);
        @(posedge clk);
        #1 annul = 1'b0; start = 1'b0;
        expect_quiet("annul", 40);
        check("annul result_kept", result, last_exp);
        repeat (2) @(posedge clk);
        run_op("after_annul", 32'd1000000, 32'd3, 1'b0, {32'd1, 32'd333333}, 34);

        // reset in the middle of an operation
        @(posedge clk);
        #1 a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1; start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midreset result", result, 64'd0);
        check("midreset ready", {63'd0, ready}, 64'd0);
        expect_quiet("midreset", 40);
        run_op("after_reset", 32'hFFFFFFFF, 32'h10, 1'b0, {32'h0000000F, 32'h0FFFFFFF}, 34);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Iterative radix-2 divider serving DIV/DIVU in the execute/memory path of the pipelined MIPS core.
- Accepts dividend/divisor plus a signed flag.
- Holds the pipeline via a stall output while iterating.
- Delivers {HI=remainder, LO=quotient} as a 64-bit result with a one-cycle ready pulse, consumed by the hilo register write path.

Parameters:
WIDTH, 32, operand width; the result is 2*WIDTH wide.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  divide request; held high by the requester until ready
signed_div  in  1  1=DIV (two's complement), 0=DIVU; sampled with start in IDLE
a  in  WIDTH  dividend; sampled with start in IDLE
b  in  WIDTH  divisor; sampled with start in IDLE
annul  in  1  flush; aborts any operation in flight
stall  out  1  pipeline hold request
ready  out  1  one-cycle pulse; result valid this cycle
result  out  2*WIDTH  {remainder, quotient}

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, counter=0, result=0, ready=0. Reset mid-operation discards it, with no ready.
- States: IDLE, DIV, FIX, DONE.
- IDLE:
  - start=1, annul=0, b!=0: latch sign(a)^sign(b) (quotient sign) and sign(a) (remainder sign), gated by signed_div; latch |a| and |b| (raw values when unsigned); clear the partial remainder; counter=0; go to DIV.
  - start=1, b==0: go directly to DONE with result={a, all-ones}, for both signed and unsigned.
- DIV: one restoring step per cycle.
  - Shift {rem,quo} left by 1, trial-subtract |b| from rem, set the quotient LSB on no borrow.
  - counter increments each step; after WIDTH steps (counter==WIDTH-1 at the edge) go to FIX.
- FIX: negate the quotient if the quotient sign=1; negate the remainder if the remainder sign=1; register into result; go to DONE.
- DONE: ready=1 for exactly one cycle; result holds its value until the next completion; go to IDLE unconditionally.
- stall = start & (state==IDLE | state==DIV | state==FIX) & ~annul. It is 0 in DONE, so the requesting stage advances in the ready cycle.
- Latency: start sampled in IDLE at edge 0; ready high in the cycle after edge WIDTH+1, i.e. 34 cycles of stall for WIDTH=32. Divide-by-zero: 1 stall cycle.
- Back-to-back: the requester must drop start, or present a new instruction, after ready. A start seen in IDLE after DONE begins a new operation.
- annul=1 in any state: next state IDLE, ready stays 0, result unchanged, stall=0 in the same cycle (combinational). annul has priority over start.
- Overflow (signed 0x80000000 / -1): quotient=0x80000000, remainder=0. This falls out of the abs/negate path; no special case.
- Remainder sign follows the dividend; quotient truncates toward zero.
- All arithmetic is unsigned on magnitudes. The trial subtract is WIDTH+1 bits wide so the borrow is visible.

Decomposition:
- Shared package div_pkg holds:
  - the state enum (IDLE/DIV/FIX/DONE)
  - the counter width localparam $clog2(WIDTH)
  - the div-by-zero quotient constant (all-ones)
- One natural sub-module: div_abs_neg. It is combinational conditional two's-complement (in, negate, out) and is used for operand abs and result fixup.
- The FSM and shift datapath stay in div_unit.

Test Plan:
- Unsigned 100/7 (signed_div=0, start held) -> stall high 34 cycles, ready pulse once, result={32'd2, 32'd14}, stall low in the ready cycle.
- Signed -7/2 (a=0xFFFFFFF9, b=2) -> result={0xFFFFFFFF, 0xFFFFFFFD}. Also 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- Divide-by-zero a=0x12345678, b=0 (signed and unsigned) -> ready after 1 stall cycle, result={0x12345678, 0xFFFFFFFF}.
- Signed overflow a=0x80000000, b=0xFFFFFFFF -> result={0x00000000, 0x80000000}. Also unsigned 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- annul pulsed at cycle 10 of DIV -> stall=0 that cycle, state IDLE next, no ready, previous result unchanged. A fresh start 2 cycles later completes correctly.
- rst asserted at cycle 20 of an operation -> outputs 0 next cycle, no ready. A subsequent 0xFFFFFFFF/0x10 unsigned -> {0xF, 0x0FFFFFFF}.
